// File: rtl/pointer_tracker_pkg.sv
// Shared life_game definitions: grid geometry, tracker states and the
// sign-magnitude layout of the pointer delta fields.
package pointer_tracker_pkg;

    localparam int CELL_SIZE = 20;
    localparam int GRID_COLS = 32;
    localparam int GRID_ROWS = 24;

    localparam int IDX_W = 5;
    localparam int PIX_W = 10;

    localparam int DIR_BIT = 8;
    localparam int MAG_MSB = 7;
    localparam int MAG_LSB = 0;

    typedef logic [DIR_BIT:0] delta_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HOLD   = 2'd1,
        ST_TOGGLE = 2'd2
    } state_t;

    // Only the presence of a magnitude matters; its value is ignored.
    function automatic logic isStep(input delta_t d);
        return |d[MAG_MSB:MAG_LSB];
    endfunction

    function automatic logic isDecrement(input delta_t d);
        return d[DIR_BIT];
    endfunction

endpackage

// File: rtl/pointer_tracker_if.sv
// Pointer bundle in, cursor/overlay and grid-memory toggle handshake out.
interface pointer_tracker_if;
    import pointer_tracker_pkg::*;

    logic             pointer_ready;
    delta_t           pointer_delta_x;
    delta_t           pointer_delta_y;
    logic             pointer_select;
    logic             edit_enable;
    logic [IDX_W-1:0] cursor_col;
    logic [IDX_W-1:0] cursor_row;
    logic [PIX_W-1:0] cursor_x;
    logic [PIX_W-1:0] cursor_y;
    logic             toggle_req;
    logic [IDX_W-1:0] toggle_col;
    logic [IDX_W-1:0] toggle_row;
    logic             toggle_ack;

    modport master (
        output pointer_ready, pointer_delta_x, pointer_delta_y, pointer_select,
        output edit_enable, toggle_ack,
        input  cursor_col, cursor_row, cursor_x, cursor_y,
        input  toggle_req, toggle_col, toggle_row
    );

    modport slave (
        input  pointer_ready, pointer_delta_x, pointer_delta_y, pointer_select,
        input  edit_enable, toggle_ack,
        output cursor_col, cursor_row, cursor_x, cursor_y,
        output toggle_req, toggle_col, toggle_row
    );

endinterface

// File: rtl/pointer_tracker_axis_stepper.sv
// One cursor axis: cell index plus its pixel coordinate, kept in step by
// adding or subtracting the cell pitch, saturating at 0 and LIMIT.
module axis_stepper #(
    parameter int IDX_W = 5,
    parameter int PIX_W = 10,
    parameter int LIMIT = 31,
    parameter int STEP  = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_step,
    input  logic             i_dec,
    output logic [IDX_W-1:0] o_index,
    output logic [PIX_W-1:0] o_pixel
);

    logic [IDX_W-1:0] r_index;
    logic [PIX_W-1:0] r_pixel;
    logic             w_atLow;
    logic             w_atHigh;

    assign w_atLow  = (r_index == '0);
    assign w_atHigh = (r_index == IDX_W'(LIMIT));

    // A step that would leave the grid leaves both index and pixel untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_index <= '0;
            r_pixel <= '0;
        end else if (i_step) begin
            if (i_dec && !w_atLow) begin
                r_index <= r_index - IDX_W'(1);
                r_pixel <= r_pixel - PIX_W'(STEP);
            end else if (!i_dec && !w_atHigh) begin
                r_index <= r_index + IDX_W'(1);
                r_pixel <= r_pixel + PIX_W'(STEP);
            end
        end
    end

    assign o_index = r_index;
    assign o_pixel = r_pixel;

endmodule

// File: rtl/pointer_tracker.sv
// Cursor tracker for the life game grid: steps and auto-repeats the cursor
// from the button pointer and issues req/ack cell toggles on select.
module pointer_tracker
    import pointer_tracker_pkg::*;
#(
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 5000000
) (
    input  logic               clk,
    input  logic               rst,
    pointer_tracker_if.slave   bus
);

    localparam int CNT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] DELAY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LOAD = CNT_W'(REPEAT_PERIOD - 1);

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_toggleReq;
    logic [IDX_W-1:0] r_toggleCol;
    logic [IDX_W-1:0] r_toggleRow;

    state_t           w_stateNext;
    logic [CNT_W-1:0] w_cntNext;
    logic             w_reqNext;
    logic             w_capture;
    logic             w_step;
    logic             w_stepX;
    logic             w_stepY;
    logic [IDX_W-1:0] w_col;
    logic [IDX_W-1:0] w_row;
    logic [PIX_W-1:0] w_x;
    logic [PIX_W-1:0] w_y;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_toggleReq <= 1'b0;
            r_toggleCol <= '0;
            r_toggleRow <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_cnt       <= w_cntNext;
            r_toggleReq <= w_reqNext;
            if (w_capture) begin
                r_toggleCol <= w_col;
                r_toggleRow <= w_row;
            end
        end
    end

    // Select wins over movement in IDLE; HOLD only accepts a new select
    // after a release back to IDLE, so each press toggles exactly once.
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_reqNext   = r_toggleReq;
        w_capture   = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.pointer_ready && bus.edit_enable) begin
                    if (bus.pointer_select) begin
                        w_capture   = 1'b1;
                        w_reqNext   = 1'b1;
                        w_stateNext = ST_TOGGLE;
                    end else begin
                        w_step      = 1'b1;
                        w_cntNext   = DELAY_LOAD;
                        w_stateNext = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (!bus.pointer_ready) begin
                    w_stateNext = ST_IDLE;
                end else if (!bus.pointer_select && bus.edit_enable) begin
                    if (r_cnt == '0) begin
                        w_step    = 1'b1;
                        w_cntNext = PERIOD_LOAD;
                    end else begin
                        w_cntNext = r_cnt - CNT_W'(1);
                    end
                end
            end
            ST_TOGGLE: begin
                if (bus.toggle_ack) begin
                    w_reqNext   = 1'b0;
                    w_cntNext   = DELAY_LOAD;
                    w_stateNext = ST_HOLD;
                end
            end
            default: begin
                w_stateNext = ST_IDLE;
            end
        endcase
    end

    assign w_stepX = w_step && isStep(bus.pointer_delta_x);
    assign w_stepY = w_step && isStep(bus.pointer_delta_y);

    axis_stepper #(
        .IDX_W (IDX_W),
        .PIX_W (PIX_W),
        .LIMIT (GRID_COLS - 1),
        .STEP  (CELL_SIZE)
    ) u_colStepper (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_stepX),
        .i_dec   (isDecrement(bus.pointer_delta_x)),
        .o_index (w_col),
        .o_pixel (w_x)
    );

    axis_stepper #(
        .IDX_W (IDX_W),
        .PIX_W (PIX_W),
        .LIMIT (GRID_ROWS - 1),
        .STEP  (CELL_SIZE)
    ) u_rowStepper (
        .clk     (clk),
        .rst     (rst),
        .i_step  (w_stepY),
        .i_dec   (isDecrement(bus.pointer_delta_y)),
        .o_index (w_row),
        .o_pixel (w_y)
    );

    assign bus.cursor_col = w_col;
    assign bus.cursor_row = w_row;
    assign bus.cursor_x   = w_x;
    assign bus.cursor_y   = w_y;
    assign bus.toggle_req = r_toggleReq;
    assign bus.toggle_col = r_toggleCol;
    assign bus.toggle_row = r_toggleRow;

endmodule

// File: tb/tb_pointer_tracker.sv
// Directed bench for pointer_tracker with short repeat timing (8 / 3 cycles).
module tb_pointer_tracker;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pointer_tracker_if bus();

    pointer_tracker #(
        .REPEAT_DELAY  (8),
        .REPEAT_PERIOD (3)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic ready, input logic [8:0] dx,
                                 input logic [8:0] dy, input logic sel);
        bus.pointer_ready   = ready;
        bus.pointer_delta_x = dx;
        bus.pointer_delta_y = dy;
        bus.pointer_select  = sel;
    endtask

    task automatic pulse(input logic [8:0] dx, input logic [8:0] dy);
        applyStimulus(1'b1, dx, dy, 1'b0);
        tick(1);
        applyStimulus(1'b0, 9'h000, 9'h000, 1'b0);
        tick(1);
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
    endtask

    task automatic checkCursor(input string tag, input int col, input int row);
        checkOutput({tag, "_col"}, 32'(bus.cursor_col), 32'(col));
        checkOutput({tag, "_row"}, 32'(bus.cursor_row), 32'(row));
        checkOutput({tag, "_x"},   32'(bus.cursor_x),   32'(col * 20));
        checkOutput({tag, "_y"},   32'(bus.cursor_y),   32'(row * 20));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.edit_enable = 1'b0;
        bus.toggle_ack  = 1'b0;
        applyStimulus(1'b0, 9'h000, 9'h000, 1'b0);
        tick(1);
        doReset();
        checkCursor("reset", 0, 0);
        checkOutput("reset_req", 32'(bus.toggle_req), 32'd0);

        bus.edit_enable = 1'b1;
        pulse(9'h014, 9'h000);
        checkCursor("right1", 1, 0);

        doReset();
        pulse(9'h114, 9'h000);
        checkCursor("leftClamp", 0, 0);
        for (int i = 0; i < 31; i++) pulse(9'h014, 9'h000);
        checkCursor("toCol31", 31, 0);
        pulse(9'h014, 9'h000);
        checkCursor("rightClamp", 31, 0);

        doReset();
        applyStimulus(1'b1, 9'h000, 9'h014, 1'b0);
        tick(8);
        checkCursor("hold8", 0, 1);
        tick(1);
        checkCursor("hold9", 0, 2);
        tick(11);
        checkCursor("hold20", 0, 5);
        applyStimulus(1'b0, 9'h000, 9'h000, 1'b0);
        tick(3);
        checkCursor("released", 0, 5);

        doReset();
        for (int i = 0; i < 3; i++) pulse(9'h014, 9'h000);
        for (int i = 0; i < 2; i++) pulse(9'h000, 9'h014);
        checkCursor("at3_2", 3, 2);
        applyStimulus(1'b1, 9'h014, 9'h000, 1'b1);
        tick(1);
        checkOutput("selReq", 32'(bus.toggle_req), 32'd1);
        checkOutput("selCol", 32'(bus.toggle_col), 32'd3);
        checkOutput("selRow", 32'(bus.toggle_row), 32'd2);
        checkCursor("selNoMove", 3, 2);
        tick(5);
        checkOutput("waitReq", 32'(bus.toggle_req), 32'd1);
        checkOutput("waitCol", 32'(bus.toggle_col), 32'd3);
        checkOutput("waitRow", 32'(bus.toggle_row), 32'd2);
        checkCursor("waitNoMove", 3, 2);
        bus.toggle_ack = 1'b1;
        tick(1);
        bus.toggle_ack = 1'b0;
        checkOutput("ackDrop", 32'(bus.toggle_req), 32'd0);
        tick(15);
        checkOutput("noRepeatReq", 32'(bus.toggle_req), 32'd0);
        checkCursor("heldSelect", 3, 2);
        applyStimulus(1'b0, 9'h000, 9'h000, 1'b0);
        tick(2);
        bus.toggle_ack = 1'b1;
        tick(2);
        bus.toggle_ack = 1'b0;
        checkOutput("strayAck", 32'(bus.toggle_req), 32'd0);

        bus.edit_enable = 1'b0;
        pulse(9'h014, 9'h000);
        checkCursor("editOff", 3, 2);
        applyStimulus(1'b1, 9'h000, 9'h000, 1'b1);
        tick(1);
        checkOutput("editOffReq", 32'(bus.toggle_req), 32'd0);
        applyStimulus(1'b0, 9'h000, 9'h000, 1'b0);
        tick(1);
        bus.edit_enable = 1'b1;
        applyStimulus(1'b1, 9'h000, 9'h000, 1'b1);
        tick(1);
        checkOutput("preRstReq", 32'(bus.toggle_req), 32'd1);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        applyStimulus(1'b0, 9'h000, 9'h000, 1'b0);
        checkOutput("rstReq", 32'(bus.toggle_req), 32'd0);
        checkCursor("rstCursor", 0, 0);
        tick(1);

        for (int i = 0; i < 5; i++) pulse(9'h014, 9'h014);
        checkCursor("at5_5", 5, 5);
        pulse(9'h114, 9'h114);
        checkCursor("diagUpLeft", 4, 4);
        for (int i = 0; i < 25; i++) pulse(9'h000, 9'h014);
        checkCursor("bottomClamp", 4, 23);
        pulse(9'h114, 9'h014);
        checkCursor("mixedClamp", 3, 23);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
